// File: rtl/ram_shuffler_pkg.sv
// Shared types and constants for the RC4 key-schedule RAM shuffler.
package ram_shuffler_pkg;

  typedef enum logic [4:0] {
    StIdle    = 5'd0,
    StReadSi  = 5'd1,
    StWaitSi  = 5'd2,
    StCalcJ   = 5'd3,
    StReadSj  = 5'd4,
    StWaitSj  = 5'd5,
    StWriteSi = 5'd6,
    StWriteSj = 5'd7,
    StDone    = 5'd8
  } state_e;

  // Clock cycles spent on each i of the key schedule.
  localparam int unsigned IterCycles = 7;

endpackage

// File: rtl/ram_shuffler.sv
// RC4 key schedule run in place on an external synchronous-read RAM: for each i, read s[i],
// advance j, read s[j], then write the two values back swapped.
module ram_shuffler
  import ram_shuffler_pkg::*;
#(
  parameter int unsigned RAM_LENGTH = 256,
  parameter int unsigned RAM_WIDTH  = 8,
  parameter int unsigned KEY_LENGTH = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [KEY_LENGTH-1:0][7:0]  key,
  input  logic [RAM_WIDTH-1:0]        ram_out,
  output logic                        finished,
  output logic                        write_enable,
  output logic [RAM_WIDTH-1:0]        ram_in,
  output logic [7:0]                  address,
  output logic [7:0]                  iTap,
  output logic [7:0]                  jTap,
  output logic [7:0]                  siTap,
  output logic [7:0]                  sjTap,
  output logic [4:0]                  stateTap
);

  state_e               state_q, state_d;
  logic [7:0]           i_q, i_d;
  logic [7:0]           j_q, j_d;
  logic [RAM_WIDTH-1:0] si_q, si_d;
  logic [RAM_WIDTH-1:0] sj_q, sj_d;

  logic [7:0]  key_byte;
  int          key_pos;
  int unsigned j_sum;

  // Key byte 0 sits in the most significant byte of the packed key.
  always_comb begin
    key_pos  = int'(KEY_LENGTH - 1 - (32'(i_q) % KEY_LENGTH));
    key_byte = '0;
    for (int k = 0; k < int'(KEY_LENGTH); k++) begin
      if (k == key_pos) key_byte = key[k];
    end
    j_sum = 32'(j_q) + 32'(ram_out) + 32'(key_byte);
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    si_d         = si_q;
    sj_d         = sj_q;
    finished     = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    ram_in       = '0;
    case (state_q)
      StIdle: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          state_d = StReadSi;
        end
      end
      StReadSi: begin
        address = i_q;
        state_d = StWaitSi;
      end
      StWaitSi: begin
        address = i_q;
        state_d = StCalcJ;
      end
      StCalcJ: begin
        si_d    = ram_out;
        j_d     = 8'(j_sum % RAM_LENGTH);
        state_d = StReadSj;
      end
      StReadSj: begin
        address = j_q;
        state_d = StWaitSj;
      end
      StWaitSj: begin
        address = j_q;
        state_d = StWriteSi;
      end
      StWriteSi: begin
        // s[j] is on ram_out this cycle; write it through while latching it.
        sj_d         = ram_out;
        write_enable = 1'b1;
        address      = i_q;
        ram_in       = ram_out;
        state_d      = StWriteSj;
      end
      StWriteSj: begin
        write_enable = 1'b1;
        address      = j_q;
        ram_in       = si_q;
        i_d          = i_q + 8'd1;
        state_d      = (i_q == 8'(RAM_LENGTH - 1)) ? StDone : StReadSi;
      end
      StDone: begin
        finished = 1'b1;
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  assign iTap     = i_q;
  assign jTap     = j_q;
  assign siTap    = 8'(si_q);
  assign sjTap    = 8'(sj_q);
  assign stateTap = state_q;

endmodule

// File: tb/tb_ram_shuffler.sv
// Randomised self-checking bench: a software RC4 key schedule predicts every RAM write and the
// final RAM image; a small 8-word instance checks iteration timing against hand-worked values.
module tb_ram_shuffler;
  import ram_shuffler_pkg::*;

  logic clk;
  logic rst_n;

  // Small instance, RAM_LENGTH = 8, constant read data.
  logic            a_start, a_finished, a_we;
  logic [2:0][7:0] a_key;
  logic [7:0]      a_ram_out, a_ram_in, a_addr;
  logic [7:0]      a_itap, a_jtap, a_sitap, a_sjtap;
  logic [4:0]      a_state;

  // Full instance, RAM_LENGTH = 256, backed by a behavioural RAM.
  logic            b_start, b_finished, b_we;
  logic [2:0][7:0] b_key;
  logic [7:0]      b_rd, b_ram_in, b_addr;
  logic [7:0]      b_itap, b_jtap, b_sitap, b_sjtap;
  logic [4:0]      b_state;

  logic [7:0] mem      [256];
  logic [7:0] init_mem [256];
  logic [7:0] ms       [256];
  logic       load;

  int exp_addr[$];
  int exp_data[$];
  int a_wa[$];
  int a_wd[$];

  int errors = 0;
  int checks = 0;

  ram_shuffler #(.RAM_LENGTH(8), .RAM_WIDTH(8), .KEY_LENGTH(3)) dut_a (
    .clk(clk), .reset(rst_n), .start(a_start), .key(a_key), .ram_out(a_ram_out),
    .finished(a_finished), .write_enable(a_we), .ram_in(a_ram_in), .address(a_addr),
    .iTap(a_itap), .jTap(a_jtap), .siTap(a_sitap), .sjTap(a_sjtap), .stateTap(a_state)
  );

  ram_shuffler #(.RAM_LENGTH(256), .RAM_WIDTH(8), .KEY_LENGTH(3)) dut_b (
    .clk(clk), .reset(rst_n), .start(b_start), .key(b_key), .ram_out(b_rd),
    .finished(b_finished), .write_enable(b_we), .ram_in(b_ram_in), .address(b_addr),
    .iTap(b_itap), .jTap(b_jtap), .siTap(b_sitap), .sjTap(b_sjtap), .stateTap(b_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: data for an address appears one cycle later.
  always @(posedge clk) begin
    if (load) begin
      for (int m = 0; m < 256; m++) mem[m] <= init_mem[m];
    end else if (b_we) begin
      mem[b_addr] <= b_ram_in;
    end
    b_rd <= mem[b_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic int kbyte(input logic [23:0] k, input int n);
    return int'((k >> (8 * (2 - n))) & 24'hff);
  endfunction

  // Compare process for the full instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_we) begin
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_write: got addr %0d data %0d, required no write",
                   b_addr, b_ram_in);
        end else begin
          check("b_write_addr", int'(b_addr), exp_addr.pop_front());
          check("b_write_data", int'(b_ram_in), exp_data.pop_front());
        end
      end
      if (b_finished) begin
        check("b_done_no_pending", exp_addr.size(), 0);
        check("b_done_addr", int'(b_addr), 0);
        check("b_done_ram_in", int'(b_ram_in), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && a_we) begin
      a_wa.push_back(int'(a_addr));
      a_wd.push_back(int'(a_ram_in));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ram(input bit random_fill);
    for (int m = 0; m < 256; m++) init_mem[m] = random_fill ? 8'($urandom) : 8'(m);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Software key schedule over a snapshot of the RAM; queues the write sequence.
  task automatic build_expect(input logic [23:0] k);
    int         j;
    logic [7:0] t;
    exp_addr.delete();
    exp_data.delete();
    for (int m = 0; m < 256; m++) ms[m] = mem[m];
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(ms[i]) + kbyte(k, i % 3)) % 256;
      exp_addr.push_back(i);
      exp_data.push_back(int'(ms[j]));
      exp_addr.push_back(j);
      exp_data.push_back(int'(ms[i]));
      t     = ms[i];
      ms[i] = ms[j];
      ms[j] = t;
    end
  endtask

  task automatic run_b(input int drop_at, input int hold_after);
    int cnt;
    b_start = 1'b1;
    tick();
    cnt = 0;
    while (!b_finished && cnt < 2000) begin
      tick();
      cnt++;
      if (cnt == drop_at) b_start = 1'b0;
    end
    check("b_done_latency", cnt, int'(IterCycles) * 256);
    for (int h = 0; h < hold_after; h++) begin
      tick();
      check("b_finished_hold", int'(b_finished), 1);
    end
    b_start = 1'b0;
    tick();
    check("b_finished_clear", int'(b_finished), 0);
    check("b_back_to_idle", int'(b_state), int'(StIdle));
  endtask

  task automatic check_final_ram();
    for (int m = 0; m < 256; m++) check("b_final_ram", int'(mem[m]), int'(ms[m]));
  endtask

  task automatic check_b_zero(input string tag);
    check({tag, "_state"}, int'(b_state), int'(StIdle));
    check({tag, "_finished"}, int'(b_finished), 0);
    check({tag, "_we"}, int'(b_we), 0);
    check({tag, "_addr"}, int'(b_addr), 0);
    check({tag, "_ram_in"}, int'(b_ram_in), 0);
    check({tag, "_taps"}, int'({b_itap, b_jtap, b_sitap, b_sjtap}), 0);
  endtask

  initial begin
    int cnt;
    int j;
    int stop;
    rst_n     = 1'b0;
    load      = 1'b0;
    a_start   = 1'b0;
    b_start   = 1'b0;
    a_key     = 24'h000001;
    b_key     = 24'h000249;
    a_ram_out = 8'h40;
    for (int m = 0; m < 256; m++) init_mem[m] = 8'h00;
    repeat (3) tick();

    check_b_zero("reset");
    check("reset_a_state", int'(a_state), int'(StIdle));
    check("reset_a_outs", int'({a_finished, a_we, a_addr, a_ram_in}), 0);
    check("reset_a_taps", int'({a_itap, a_jtap, a_sitap, a_sjtap}), 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_waits_for_start", int'(b_state), int'(StIdle));

    // Small instance: constant 0x40 read data, key byte 2 = 1.
    a_start = 1'b1;
    tick();
    cnt = 0;
    while (!a_finished && cnt < 200) begin
      tick();
      cnt++;
    end
    check("a_done_latency", cnt, 56);
    check("a_write_count", a_wa.size(), 16);
    if (a_wa.size() >= 6) begin
      check("a_pair0_i", a_wa[0], 0);
      check("a_pair0_j", a_wa[1], 0);
      check("a_pair1_i", a_wa[2], 1);
      check("a_pair1_j", a_wa[3], 0);
      check("a_pair2_i", a_wa[4], 2);
      check("a_pair2_j", a_wa[5], 1);
    end
    j = 0;
    for (int i = 0; i < 8 && 2 * i + 1 < a_wa.size(); i++) begin
      j = (j + 64 + kbyte(24'h000001, i % 3)) % 8;
      check("a_write_i", a_wa[2 * i], i);
      check("a_write_j", a_wa[2 * i + 1], j);
      check("a_data_si", a_wd[2 * i], 64);
      check("a_data_sj", a_wd[2 * i + 1], 64);
    end
    a_start = 1'b0;
    tick();
    check("a_back_to_idle", int'(a_state), int'(StIdle));

    // Run 1: identity RAM, known key; pin the model's first iterations by hand.
    load_ram(1'b0);
    b_key = 24'h000249;
    build_expect(24'h000249);
    check("model_w2_addr", exp_addr[2], 1);
    check("model_w2_data", exp_data[2], 3);
    check("model_w3_addr", exp_addr[3], 3);
    check("model_w4_data", exp_data[4], 78);
    check("model_w5_addr", exp_addr[5], 78);
    run_b(-1, 0);
    check_final_ram();

    // Run 2: random RAM and key, start dropped 20 cycles in.
    load_ram(1'b1);
    b_key = 24'($urandom);
    build_expect(b_key);
    run_b(20, 0);
    check_final_ram();

    // Run 3: reset mid-run.
    b_key = 24'($urandom);
    build_expect(b_key);
    stop  = int'($urandom_range(10, 1700));
    b_start = 1'b1;
    for (int c = 0; c < stop; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_b_zero("midrun_reset");
    exp_addr.delete();
    exp_data.delete();
    b_start = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", int'(b_state), int'(StIdle));

    // Run 4: restart from the partially shuffled RAM, start held after done.
    b_key = 24'($urandom);
    build_expect(b_key);
    run_b(-1, 5);
    check_final_ram();

    // Run 5: start low then high again gives a complete new shuffle.
    b_key = 24'($urandom);
    build_expect(b_key);
    run_b(-1, 0);
    check_final_ram();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
